// File: rtl/timer_ctrl_8b_if.sv
// Bus-side and counter-side signal bundle for timer_ctrl_8b.
// The slave modport is the timer control block; the master modport is whoever drives it.
interface timer_ctrl_8b_if #(
  parameter int PRESCALE_W = 8
);
  logic                  start;
  logic                  stop;
  logic                  mode;
  logic [7:0]            reload;
  logic [7:0]            compare;
  logic [PRESCALE_W-1:0] prescale;
  logic                  irq_ack;
  logic                  busy;
  logic                  match;
  logic                  ovf;
  logic                  irq;
  logic                  cnt_en;
  logic                  cnt_ld;
  logic [7:0]            cnt_value;
  logic [7:0]            count;

  modport slave (
    input  start,
    input  stop,
    input  mode,
    input  reload,
    input  compare,
    input  prescale,
    input  irq_ack,
    input  count,
    output busy,
    output match,
    output ovf,
    output irq,
    output cnt_en,
    output cnt_ld,
    output cnt_value
  );

  modport master (
    output start,
    output stop,
    output mode,
    output reload,
    output compare,
    output prescale,
    output irq_ack,
    output count,
    input  busy,
    input  match,
    input  ovf,
    input  irq,
    input  cnt_en,
    input  cnt_ld,
    input  cnt_value
  );
endinterface

// File: rtl/timer_ctrl_8b.sv
// Prescaled one-shot / auto-reload timer control for an 8-bit load/count counter.
// Produces compare-match and overflow pulses plus a sticky, acknowledgeable interrupt.
module timer_ctrl_8b #(
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rstz,
  timer_ctrl_8b_if.slave    bus,
  inout  wire               dvdd,
  inout  wire               dgnd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] psc;
  logic                  match_q;
  logic                  ovf_q;
  logic                  irq_q;

  logic       restart;
  logic       tick;
  logic       run_tick;
  logic       at_top;
  logic       match_set;
  logic       ovf_set;
  logic       cnt_en;
  logic       cnt_ld;
  logic [7:0] cnt_value;
  logic       busy;

  wire unused_supply = dvdd ^ dgnd;

  assign restart   = bus.start & ~bus.stop;
  assign tick      = (state == RUN) && (psc >= bus.prescale);
  // A start or stop request in RUN pre-empts whatever the tick would have done.
  assign run_tick  = tick & ~bus.stop & ~bus.start;
  assign at_top    = (bus.count == 8'hFF);
  assign match_set = run_tick & (bus.count == bus.compare);
  assign ovf_set   = run_tick & at_top;

  // The counter clears whenever en is low, so holding a value means reloading it.
  always_comb begin
    cnt_en    = 1'b0;
    cnt_ld    = 1'b0;
    cnt_value = 8'h00;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        cnt_en    = 1'b1;
        cnt_ld    = 1'b1;
        cnt_value = bus.reload;
        busy      = 1'b1;
      end
      RUN: begin
        cnt_en    = 1'b1;
        cnt_ld    = 1'b1;
        cnt_value = bus.count;
        busy      = 1'b1;
        if (run_tick) begin
          if (!at_top) begin
            cnt_ld = 1'b0;
          end else if (bus.mode) begin
            cnt_value = bus.reload;
          end
        end
      end
      default: begin
        cnt_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state   <= IDLE;
      psc     <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      match_q <= match_set;
      ovf_q   <= ovf_set;

      // A fresh event on the acknowledge edge keeps the interrupt asserted.
      if (match_set || ovf_set) begin
        irq_q <= 1'b1;
      end else if (bus.irq_ack) begin
        irq_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (restart) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          psc   <= '0;
          state <= bus.stop ? IDLE : RUN;
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (bus.start) begin
            state <= LOAD;
          end else if (tick) begin
            psc <= '0;
            if (at_top && !bus.mode) begin
              state <= IDLE;
            end
          end else begin
            psc <= psc + PRESCALE_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cnt_en    = cnt_en;
  assign bus.cnt_ld    = cnt_ld;
  assign bus.cnt_value = cnt_value;
  assign bus.busy      = busy;
  assign bus.match     = match_q;
  assign bus.ovf       = ovf_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_timer_ctrl_8b.sv
// Scoreboard bench for timer_ctrl_8b closed around a behavioural COUNTER_8b model.
// The driver pushes predicted post-edge values; the monitor pops and compares after each edge.
module tb_timer_ctrl_8b;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       match;
    logic       ovf;
    logic       irq;
  } exp_t;

  logic clk  = 1'b0;
  logic rstz = 1'b0;
  wire  dvdd;
  wire  dgnd;
  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  always #5 clk = ~clk;

  timer_ctrl_8b_if #(.PRESCALE_W(8)) bus ();

  timer_ctrl_8b #(.PRESCALE_W(8)) dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus),
    .dvdd (dvdd),
    .dgnd (dgnd)
  );

  // Behavioural COUNTER_8b: clears without en, loads with ld, else increments.
  logic [7:0] cnt_q = 8'h00;
  always @(posedge clk) begin
    cnt_q <= !bus.cnt_en ? 8'h00 : (bus.cnt_ld ? bus.cnt_value : cnt_q + 8'h01);
  end
  assign bus.count = cnt_q;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       cfg_mode     = 1'b0;
  logic [7:0] cfg_reload   = 8'h00;
  logic [7:0] cfg_compare  = 8'h00;
  logic [7:0] cfg_prescale = 8'h00;

  int         m_st      = M_IDLE;
  int         m_elapsed = 0;
  logic [7:0] m_cnt     = 8'h00;
  logic       m_irq     = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    m_st      = M_IDLE;
    m_elapsed = 0;
    m_cnt     = 8'h00;
    m_irq     = 1'b0;
  endtask

  // Timer rules: a tick every prescale+1 run cycles; 0xFF either reloads or ends the run.
  task automatic modelStep(input logic s, input logic p, input logic a, output exp_t e);
    logic       ev_match;
    logic       ev_ovf;
    logic [7:0] next_cnt;
    ev_match = 1'b0;
    ev_ovf   = 1'b0;
    next_cnt = m_cnt;
    if (m_st == M_IDLE) begin
      next_cnt = 8'h00;
      if (s && !p) m_st = M_LOAD;
    end else if (m_st == M_LOAD) begin
      next_cnt  = cfg_reload;
      m_elapsed = 0;
      m_st      = p ? M_IDLE : M_RUN;
    end else begin
      if (p) begin
        m_st = M_IDLE;
      end else if (s) begin
        m_st = M_LOAD;
      end else if (m_elapsed >= int'(cfg_prescale)) begin
        m_elapsed = 0;
        ev_match  = (m_cnt == cfg_compare);
        if (m_cnt == 8'd255) begin
          ev_ovf = 1'b1;
          if (cfg_mode) next_cnt = cfg_reload;
          else          m_st     = M_IDLE;
        end else begin
          next_cnt = m_cnt + 8'd1;
        end
      end else begin
        m_elapsed++;
      end
    end
    if (ev_match || ev_ovf) m_irq = 1'b1;
    else if (a)             m_irq = 1'b0;
    m_cnt   = next_cnt;
    e.count = m_cnt;
    e.busy  = (m_st != M_IDLE);
    e.match = ev_match;
    e.ovf   = ev_ovf;
    e.irq   = m_irq;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic a);
    exp_t e;
    @(negedge clk);
    bus.mode     = cfg_mode;
    bus.reload   = cfg_reload;
    bus.compare  = cfg_compare;
    bus.prescale = cfg_prescale;
    bus.start    = s;
    bus.stop     = p;
    bus.irq_ack  = a;
    modelStep(s, p, a, e);
    exp_q.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},      {7'd0, bus.busy},   8'h00);
    checkOutput({tag, "_match"},     {7'd0, bus.match},  8'h00);
    checkOutput({tag, "_ovf"},       {7'd0, bus.ovf},    8'h00);
    checkOutput({tag, "_irq"},       {7'd0, bus.irq},    8'h00);
    checkOutput({tag, "_cnt_en"},    {7'd0, bus.cnt_en}, 8'h00);
    checkOutput({tag, "_cnt_ld"},    {7'd0, bus.cnt_ld}, 8'h00);
    checkOutput({tag, "_cnt_value"}, bus.cnt_value,      8'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("count", bus.count,          e.count);
        checkOutput("busy",  {7'd0, bus.busy},   {7'd0, e.busy});
        checkOutput("match", {7'd0, bus.match},  {7'd0, e.match});
        checkOutput("ovf",   {7'd0, bus.ovf},    {7'd0, e.ovf});
        checkOutput("irq",   {7'd0, bus.irq},    {7'd0, e.irq});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : driver
    int ld_total;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.irq_ack  = 1'b0;
    bus.mode     = 1'b0;
    bus.reload   = 8'h00;
    bus.compare  = 8'h00;
    bus.prescale = 8'h00;
    rstz         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rstz = 1'b1;
    modelReset();
    idleCycles(2);

    $display("[TB] auto-reload, prescale 0");
    cfg_mode = 1'b1; cfg_reload = 8'hFC; cfg_compare = 8'hFE; cfg_prescale = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(10);

    $display("[TB] interrupt acknowledge racing a new match");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idleCycles(1);

    $display("[TB] prescale hold");
    cfg_mode = 1'b1; cfg_reload = 8'h10; cfg_compare = 8'h00; cfg_prescale = 8'h03;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    ld_total = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      #1;
      ld_total += int'(bus.cnt_ld);
    end
    checkOutput("ld_cycles_of_16", 8'(ld_total), 8'd12);
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] one-shot");
    cfg_mode = 1'b0; cfg_reload = 8'hFE; cfg_compare = 8'h00; cfg_prescale = 8'h02;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(12);

    $display("[TB] control priority");
    cfg_mode = 1'b1; cfg_reload = 8'h3C; cfg_compare = 8'h00; cfg_prescale = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(5);
    cfg_reload = 8'h05;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    idleCycles(2);

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) cfg_mode = 1'($urandom_range(1));
      if ($urandom_range(15) == 0)
        cfg_reload = ($urandom_range(1) == 0) ? 8'($urandom_range(255)) : 8'hF8 + 8'($urandom_range(7));
      if ($urandom_range(15) == 0)
        cfg_compare = ($urandom_range(1) == 0) ? 8'($urandom_range(255)) : 8'hF8 + 8'($urandom_range(7));
      if ($urandom_range(15) == 0) cfg_prescale = 8'($urandom_range(3));
      applyStimulus(($urandom_range(19) == 0), ($urandom_range(39) == 0), ($urandom_range(7) == 0));
    end

    $display("[TB] asynchronous reset mid-run");
    cfg_mode = 1'b1; cfg_reload = 8'h80; cfg_compare = 8'h81; cfg_prescale = 8'h00;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(4);
    @(negedge clk);
    #2;
    rstz = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rstz = 1'b1;
    modelReset();
    idleCycles(3);

    @(posedge clk);
    #2;
    checkOutput("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_8b.md
# timer_ctrl_8b

Control stage for the 8-bit load/count counter (COUNTER_8b). It drives the counter's `en`, `ld` and `value` inputs and consumes its `count` output. It turns the free-running counter into a prescaled timer with one-shot or auto-reload operation, compare-match and overflow event pulses, and a level interrupt with acknowledge. It sits between the bus-side timer registers and COUNTER_8b.

## Interface
Parameters:
- `PRESCALE_W`, default 8: width of the prescaler compare value and internal prescaler counter.

Ports:
- `clk` in 1: system clock, rising edge.
- `rstz` in 1: asynchronous, active-low reset.
- `start` in 1: arm/restart request, sampled each edge.
- `stop` in 1: halt request; priority over `start`.
- `mode` in 1: 0 = one-shot, 1 = auto-reload; sampled on each tick.
- `reload` in 8: start/reload value.
- `compare` in 8: match value.
- `prescale` in PRESCALE_W: a tick occurs every `prescale`+1 RUN cycles.
- `count` in 8: from the counter's `count` output.
- `irq_ack` in 1: clears `irq`.
- `cnt_en` out 1: to counter `en`.
- `cnt_ld` out 1: to counter `ld`.
- `cnt_value` out 8: to counter `value`.
- `busy` out 1: high in LOAD and RUN.
- `match` out 1: one-cycle compare pulse.
- `ovf` out 1: one-cycle overflow pulse.
- `irq` out 1: sticky interrupt.
- `dvdd` inout 1: digital supply.
- `dgnd` inout 1: digital ground.

## Operation
- States: IDLE, LOAD, RUN. Internal registers: `psc` (PRESCALE_W bits), `match`, `ovf`, `irq`.
- The counter clears whenever `en`=0. To hold a count, this block keeps `cnt_en`=1, `cnt_ld`=1 and `cnt_value`=`count`.
- **IDLE**:
  - `cnt_en`=0, `cnt_ld`=0, `cnt_value`=0, `busy`=0.
  - `start`=1 & `stop`=0 → LOAD.
- **LOAD** (exactly one cycle):
  - `cnt_en`=1, `cnt_ld`=1, `cnt_value`=`reload`, `psc`←0.
  - → RUN.
- **RUN**:
  - `cnt_en`=1.
  - Tick condition: `psc` >= `prescale`. The >= form covers `prescale` being lowered mid-run.
  - Non-tick cycle: `cnt_ld`=1, `cnt_value`=`count` (hold), `psc`←`psc`+1.
  - Tick with `count`≠8'hFF: `cnt_ld`=0 (counter increments), `psc`←0.
  - Tick with `count`=8'hFF:
    - `ovf` pulses.
    - `mode`=1: `cnt_ld`=1, `cnt_value`=`reload`, `psc`←0, stay in RUN.
    - `mode`=0: → IDLE. The counter clears on the next edge.
  - Any tick with `count`=`compare`: `match` pulses. This is evaluated on the pre-increment value and can coincide with `ovf`.
- `start` in RUN (with `stop`=0) → LOAD (restart), and no tick action is taken that cycle.
- `stop`=1 in any state → IDLE on the next edge; no event pulses.
- **irq**:
  - Set on the edge where `match` or `ovf` is set.
  - Cleared by `irq_ack`=1 only if no new event occurs on that same edge (a new event wins).

## Timing
- Reset (`rstz`=0, asynchronous):
  - State IDLE, `psc`=0.
  - `cnt_en`=0, `cnt_ld`=0, `cnt_value`=0, `busy`=0, `match`=0, `ovf`=0, `irq`=0.
- Deasserting `rstz` mid-run leaves the block in IDLE; the counter clears via `cnt_en`=0.
- `start` sampled at edge N → LOAD during cycle N..N+1 → `count`=`reload` after edge N+1 → first tick edge is N+2+`prescale`.
- With `prescale`=P, `count` advances every P+1 clocks; P=0 advances every clock.
- `match` and `ovf` are registered: high for the single cycle following the tick edge. Reset value 0.
- `cnt_en`, `cnt_ld`, `cnt_value` and `busy` are combinational from state, `psc`, `count` and inputs.

## Test plan
- Async reset: in RUN, drop `rstz` between edges → all outputs 0 immediately. Release → IDLE; `count`=0 after the next edge.
- Auto-reload, P=0: `reload`=8'hFC, `compare`=8'hFE, `mode`=1, pulse `start` → `count` runs FC,FD,FE,FF,FC,FD… each clock. `match` pulses the cycle after FE is ticked; `ovf` pulses the cycle after FF is ticked; `irq`=1.
- Prescale hold: `prescale`=3, `reload`=8'h10 → `count` holds each value for exactly 4 clocks (10,11,12…), `cnt_ld`=1 on 3 of every 4 cycles.
- One-shot: `mode`=0, `reload`=8'hFE, `prescale`=2 → FE for 3 clocks, FF for 3 clocks, then `ovf` pulse. State → IDLE, `busy`=0, `count`=0 one edge later.
- Interrupt race: `irq`=1 and `irq_ack`=1 on the same edge as a new `match` → `irq` stays 1. A later `irq_ack` alone → `irq`=0.
- Control priority: `stop`=`start`=1 in RUN → IDLE, no pulses. `start` alone in RUN at `count`=8'h40 with `reload`=8'h05 → LOAD, then `count`=05.
